mem_wb_stage: RTL

- Memory-access stage plus MEM/WB pipeline register of the MIPS32 core.
- Consumes EX/MEM signals, drives the data-memory req/ack port and aligns/extends load data.
- Registers the writeback triple (wb_reg_write, wb_rt_rd, wb_write_data) that feeds the register file write port directly.
- Stalls upstream stages while a memory transaction is outstanding.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/mem_wb_stage_load_aligner.sv | 26 ++
 rtl/mem_wb_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS32 memory/writeback stage: access sizes,
// FSM states and byte-enable patterns.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_wb_stage_load_aligner.sv
// Load data alignment: selects the addressed byte/half lane of a read word
// and zero- or sign-extends it to 32 bits.
module load_aligner
    import mips_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS32 memory-access stage and MEM/WB pipeline register.
// Optional macro MEM_ALIGN_EXC_EN: trap misaligned half/word accesses instead of issuing them.
module mem_wb_stage
    import mips_mem_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 0,
    parameter int TIMEOUT_W    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_signed,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rt_rd,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rt_rd,
    output logic [31:0] wb_write_data,
    output logic        mem_error,
    output logic        mem_align_exc
);

    mem_state_t state, next_state;

    logic [31:0]          cap_addr;
    logic [31:0]          cap_store_data;
    logic [1:0]           cap_size;
    logic                 cap_signed;
    logic                 cap_load;
    logic                 cap_reg_write;
    logic [4:0]           cap_rt_rd;
    logic [TIMEOUT_W-1:0] wait_count;

    logic        is_mem;
    logic        align_fault;
    logic        start_access;
    logic        timeout_hit;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_data;

    assign is_mem = ex_mem_read | ex_mem_write;

`ifdef MEM_ALIGN_EXC_EN
    // Size 2'b11 is a word, so size[1] covers both word encodings.
    assign align_fault = (state == ST_IDLE) && ex_valid && is_mem &&
                         (((ex_mem_size == SZ_HALF) && ex_alu_result[0]) ||
                          (ex_mem_size[1] && (ex_alu_result[1:0] != 2'b00)));
    assign mem_align_exc = align_fault;
`else
    assign align_fault   = 1'b0;
    assign mem_align_exc = 1'b0;
`endif

    // An ack landing in the final allowed cycle completes normally.
    assign timeout_hit = (DMEM_TIMEOUT != 0) && !dmem_ack &&
                         (wait_count == TIMEOUT_W'(DMEM_TIMEOUT - 1));

    always_comb begin
        store_be    = BE_WORD;
        store_wdata = cap_store_data;
        case (cap_size)
            SZ_BYTE: begin
                store_be    = BE_BYTE0 << cap_addr[1:0];
                store_wdata = {4{cap_store_data[7:0]}};
            end
            SZ_HALF: begin
                store_be    = cap_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                store_wdata = {2{cap_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_aligner u_load_aligner (
        .addr     (cap_addr[1:0]),
        .size     (cap_size),
        .sign_ext (cap_signed),
        .rdata    (dmem_rdata),
        .data     (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        start_access = 1'b0;
        mem_stall    = 1'b0;
        mem_error    = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = 32'h0;
        dmem_be      = 4'h0;
        dmem_wdata   = 32'h0;
        case (state)
            ST_IDLE: begin
                if (ex_valid && is_mem && !align_fault) begin
                    start_access = 1'b1;
                    mem_stall    = 1'b1;
                    next_state   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = !cap_load;
                dmem_addr  = {cap_addr[31:2], 2'b00};
                dmem_be    = store_be;
                dmem_wdata = store_wdata;
                if (dmem_ack) begin
                    next_state = ST_IDLE;
                end else if (timeout_hit) begin
                    mem_error  = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A simultaneous read and write request is handled as a load.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_addr       <= 32'h0;
            cap_store_data <= 32'h0;
            cap_size       <= SZ_BYTE;
            cap_signed     <= 1'b0;
            cap_load       <= 1'b0;
            cap_reg_write  <= 1'b0;
            cap_rt_rd      <= 5'd0;
            wait_count     <= '0;
        end else if (start_access) begin
            cap_addr       <= ex_alu_result;
            cap_store_data <= ex_store_data;
            cap_size       <= ex_mem_size;
            cap_signed     <= ex_mem_signed;
            cap_load       <= ex_mem_read;
            cap_reg_write  <= ex_reg_write;
            cap_rt_rd      <= ex_rt_rd;
            wait_count     <= '0;
        end else if ((state == ST_ACCESS) && !dmem_ack) begin
            wait_count <= wait_count + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_reg_write  <= 1'b0;
            wb_rt_rd      <= 5'd0;
            wb_write_data <= 32'h0;
        end else if ((state == ST_IDLE) && ex_valid && !is_mem) begin
            wb_reg_write  <= ex_reg_write;
            wb_rt_rd      <= ex_rt_rd;
            wb_write_data <= ex_alu_result;
        end else if ((state == ST_ACCESS) && dmem_ack && cap_load) begin
            wb_reg_write  <= cap_reg_write;
            wb_rt_rd      <= cap_rt_rd;
            wb_write_data <= load_data;
        end else begin
            wb_reg_write  <= 1'b0;
            wb_rt_rd      <= 5'd0;
            wb_write_data <= 32'h0;
        end
    end

endmodule
